// File: rtl/lock_lockout_ctrl_if.sv
// Signal bundle between the key pins / lock core and the lockout guard.
// fail_pulse and pass_pulse are single-cycle strobes, sampled on the clk edge with no handshake; key_in and clr_alarm are levels.
interface lock_lockout_ctrl_if;
  logic [3:0] key_in;
  logic       fail_pulse;
  logic       pass_pulse;
  logic       clr_alarm;
  logic [3:0] key_out;
  logic       locked_out;
  logic       alarm;
  logic [7:0] remaining_s;
  logic [3:0] fail_count;
  logic [1:0] state_dbg;

  modport master (
    output key_in, fail_pulse, pass_pulse, clr_alarm,
    input  key_out, locked_out, alarm, remaining_s, fail_count, state_dbg
  );

  modport slave (
    input  key_in, fail_pulse, pass_pulse, clr_alarm,
    output key_out, locked_out, alarm, remaining_s, fail_count, state_dbg
  );
endinterface

// File: rtl/lock_lockout_ctrl.sv
// Brute-force guard for the keypad lock: counts failed attempts, gates keys during
// doubling timed penalties, and latches an alarm after repeated lockouts.
module lock_lockout_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int BASE_PENALTY_S = 10,
  parameter int MAX_PENALTY_S  = 80,
  parameter int ALARM_LEVEL    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  lock_lockout_ctrl_if.slave   bus
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [3:0]      FAIL_LAST = 4'(MAX_FAILS - 1);
  localparam logic [3:0]      ALARM_LVL = 4'(ALARM_LEVEL);
  localparam logic [7:0]      BASE      = 8'(BASE_PENALTY_S);
  localparam logic [7:0]      MAX_P     = 8'(MAX_PENALTY_S);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_PENALTY = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    fail_cnt, fail_cnt_nxt;
  logic [3:0]    lockouts, lockouts_nxt;
  logic [7:0]    penalty, penalty_nxt;
  logic [7:0]    remaining, remaining_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt;

  logic [3:0]    lock_inc;
  logic [8:0]    penalty_dbl;
  logic [7:0]    penalty_next_lockout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARMED;
      fail_cnt  <= 4'd0;
      lockouts  <= 4'd0;
      penalty   <= BASE;
      remaining <= 8'd0;
      prescaler <= '0;
    end else begin
      state     <= state_nxt;
      fail_cnt  <= fail_cnt_nxt;
      lockouts  <= lockouts_nxt;
      penalty   <= penalty_nxt;
      remaining <= remaining_nxt;
      prescaler <= prescaler_nxt;
    end
  end

  // 9-bit doubling so a penalty above 127 s saturates instead of wrapping.
  always_comb begin
    lock_inc             = (lockouts == 4'd15) ? 4'd15 : lockouts + 4'd1;
    penalty_dbl          = {penalty, 1'b0};
    penalty_next_lockout = (penalty_dbl > {1'b0, MAX_P}) ? MAX_P : penalty_dbl[7:0];
  end

  always_comb begin
    state_nxt     = state;
    fail_cnt_nxt  = fail_cnt;
    lockouts_nxt  = lockouts;
    penalty_nxt   = penalty;
    remaining_nxt = remaining;
    prescaler_nxt = '0;

    unique case (state)
      ST_ARMED: begin
        if (bus.pass_pulse) begin
          fail_cnt_nxt = 4'd0;
          lockouts_nxt = 4'd0;
          penalty_nxt  = BASE;
        end else if (bus.fail_pulse) begin
          if (fail_cnt < FAIL_LAST) begin
            fail_cnt_nxt = fail_cnt + 4'd1;
          end else begin
            fail_cnt_nxt = 4'd0;
            lockouts_nxt = lock_inc;
            if (lock_inc == ALARM_LVL) begin
              state_nxt = ST_ALARM;
            end else begin
              state_nxt     = ST_PENALTY;
              remaining_nxt = penalty;
              penalty_nxt   = penalty_next_lockout;
            end
          end
        end
      end

      ST_PENALTY: begin
        if (prescaler == PRE_LAST) begin
          if (remaining <= 8'd1) begin
            state_nxt     = ST_RELEASE;
            remaining_nxt = 8'd0;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end else begin
          prescaler_nxt = prescaler + PW'(1);
        end
      end

      // Wait for every key to be up so the core never sees a held key as a fresh press.
      ST_RELEASE: begin
        if (bus.key_in == 4'hf) state_nxt = ST_ARMED;
      end

      ST_ALARM: begin
        remaining_nxt = 8'd0;
        if (bus.clr_alarm) begin
          state_nxt    = ST_RELEASE;
          lockouts_nxt = 4'd0;
          penalty_nxt  = BASE;
          fail_cnt_nxt = 4'd0;
        end
      end

      default: state_nxt = ST_ARMED;
    endcase
  end

  assign bus.key_out     = (state == ST_ARMED) ? bus.key_in : 4'hf;
  assign bus.locked_out  = (state != ST_ARMED);
  assign bus.alarm       = (state == ST_ALARM);
  assign bus.remaining_s = remaining;
  assign bus.fail_count  = fail_cnt;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_lock_lockout_ctrl.sv
// Bench for lock_lockout_ctrl: directed scenarios plus random traffic against a
// seconds/cycles reference model of the lockout rules.
module tb_lock_lockout_ctrl;
  localparam int CLK_HZ      = 10;
  localparam int MAX_FAILS   = 3;
  localparam int BASE        = 2;
  localparam int MAXP        = 5;
  localparam int ALARM_LEVEL = 3;

  localparam int M_ARMED = 0;
  localparam int M_PEN   = 1;
  localparam int M_REL   = 2;
  localparam int M_ALARM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lock_lockout_ctrl_if bus();

  lock_lockout_ctrl #(
    .CLK_HZ(CLK_HZ), .MAX_FAILS(MAX_FAILS), .BASE_PENALTY_S(BASE),
    .MAX_PENALTY_S(MAXP), .ALARM_LEVEL(ALARM_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int         m_mode, m_fails, m_lockouts, m_cycles_left;
  logic [3:0] cur_key;

  function automatic int pen_for(int k);
    int v;
    v = BASE << (k - 1);
    return (v > MAXP) ? MAXP : v;
  endfunction

  function automatic void model_reset();
    m_mode = M_ARMED; m_fails = 0; m_lockouts = 0; m_cycles_left = 0;
  endfunction

  function automatic void model_update(bit f, bit p, bit c, logic [3:0] k);
    case (m_mode)
      M_ARMED: begin
        if (p) begin
          m_fails = 0; m_lockouts = 0;
        end else if (f) begin
          if (m_fails + 1 < MAX_FAILS) m_fails++;
          else begin
            m_fails = 0;
            if (m_lockouts < 15) m_lockouts++;
            if (m_lockouts == ALARM_LEVEL) m_mode = M_ALARM;
            else begin
              m_mode = M_PEN;
              m_cycles_left = pen_for(m_lockouts) * CLK_HZ;
            end
          end
        end
      end
      M_PEN: begin
        m_cycles_left--;
        if (m_cycles_left == 0) m_mode = M_REL;
      end
      M_REL:   if (k == 4'hf) m_mode = M_ARMED;
      default: if (c) begin m_mode = M_REL; m_lockouts = 0; m_fails = 0; end
    endcase
  endfunction

  function automatic int exp_rem();
    return (m_mode == M_PEN) ? (m_cycles_left + CLK_HZ - 1) / CLK_HZ : 0;
  endfunction

  // {key_out, locked_out, alarm, remaining_s, fail_count}
  function automatic logic [17:0] exp_vec();
    logic [3:0] ko;
    ko = (m_mode == M_ARMED) ? cur_key : 4'hf;
    return {ko, m_mode != M_ARMED, m_mode == M_ALARM, 8'(exp_rem()), 4'(m_fails)};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.key_out, bus.locked_out, bus.alarm, bus.remaining_s, bus.fail_count};
  endfunction

  task automatic step(bit f, bit p, bit c, logic [3:0] k);
    bus.fail_pulse = f; bus.pass_pulse = p; bus.clr_alarm = c; bus.key_in = k;
    cur_key = k;
    @(posedge clk);
    model_update(f, p, c, k);
    #1;
  endtask

  task automatic test_reset();
    bus.key_in = 4'ha; bus.fail_pulse = 0; bus.pass_pulse = 0; bus.clr_alarm = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== {4'ha, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), {4'ha, 1'b0, 1'b0, 8'd0, 4'd0});
    end
    bus.key_in = 4'h5;
    #1;
    total++;
    if (bus.key_out !== 4'h5) begin
      bad++; $display("FAIL reset_passthru got=%h exp=5", bus.key_out);
    end
    rst = 1'b0;
    model_reset();
    cur_key = 4'h5;
  endtask

  task automatic test_fail_pass();
    int want[3] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      logic [3:0] k;
      k = 4'($urandom_range(0, 14));
      step(i < 2, i == 2, 0, k);
      total++;
      if (bus.fail_count !== 4'(want[i]) || bus.key_out !== k || bus.locked_out !== 1'b0) begin
        bad++;
        $display("FAIL fail_pass[%0d] got cnt=%0d key=%h lk=%b exp cnt=%0d key=%h lk=0",
                 i, bus.fail_count, bus.key_out, bus.locked_out, want[i], k);
      end
    end
  endtask

  task automatic test_lockout();
    repeat (3) step(1, 0, 0, 4'hf);
    total++;
    if ({bus.key_out, bus.locked_out, bus.remaining_s} !== {4'hf, 1'b1, 8'd2}) begin
      bad++; $display("FAIL lockout_entry got key=%h lk=%b rem=%0d exp key=f lk=1 rem=2",
                      bus.key_out, bus.locked_out, bus.remaining_s);
    end
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 4'hf);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL lockout_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 10) begin
        total++;
        if (bus.remaining_s !== 8'd1) begin
          bad++; $display("FAIL lockout_rem_at10 got=%0d exp=1", bus.remaining_s);
        end
      end
    end
    total++;
    if (bus.locked_out !== 1'b1 || bus.remaining_s !== 8'd0) begin
      bad++; $display("FAIL lockout_release got lk=%b rem=%0d exp lk=1 rem=0", bus.locked_out, bus.remaining_s);
    end
    step(0, 0, 0, 4'hf);
    step(0, 0, 0, 4'h3);
    total++;
    if (bus.locked_out !== 1'b0 || bus.key_out !== 4'h3) begin
      bad++; $display("FAIL lockout_rearm got lk=%b key=%h exp lk=0 key=3", bus.locked_out, bus.key_out);
    end
  endtask

  task automatic test_hold_key();
    int extra = 0;
    int budget = 100;
    repeat (3) step(1, 0, 0, 4'he);
    total++;
    if (bus.remaining_s !== 8'd4) begin
      bad++; $display("FAIL hold_second_penalty got=%0d exp=4", bus.remaining_s);
    end
    while (extra < 5 && budget > 0) begin
      step(0, 0, 0, 4'he);
      budget--;
      if (m_mode == M_REL) extra++;
      total++;
      if (bus.key_out !== 4'hf || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL hold_gated got=%h exp=%h", obs_vec(), exp_vec());
      end
    end
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL hold_timeout got=budget_out exp=release_reached");
    end
    step(0, 0, 0, 4'hf);
    step(0, 0, 0, 4'he);
    total++;
    if (bus.locked_out !== 1'b0 || bus.key_out !== 4'he) begin
      bad++; $display("FAIL hold_rearm got lk=%b key=%h exp lk=0 key=e", bus.locked_out, bus.key_out);
    end
  endtask

  task automatic run_out_penalty(string name);
    int budget = 80;
    while (m_mode != M_ARMED && budget > 0) begin
      step(0, 0, 0, 4'hf);
      budget--;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL %s_run got=%h exp=%h", name, obs_vec(), exp_vec());
      end
    end
    total++;
    if (budget == 0 || bus.locked_out !== 1'b0) begin
      bad++; $display("FAIL %s_rearm got lk=%b exp lk=0", name, bus.locked_out);
    end
  endtask

  task automatic test_alarm();
    repeat (3) step(1, 0, 0, 4'hf);
    total++;
    if ({bus.alarm, bus.locked_out, bus.remaining_s, bus.key_out} !== {1'b1, 1'b1, 8'd0, 4'hf}) begin
      bad++; $display("FAIL alarm_entry got al=%b lk=%b rem=%0d key=%h exp al=1 lk=1 rem=0 key=f",
                      bus.alarm, bus.locked_out, bus.remaining_s, bus.key_out);
    end
    step(1, 1, 0, 4'hf);
    step(0, 1, 0, 4'hf);
    total++;
    if (bus.alarm !== 1'b1) begin
      bad++; $display("FAIL alarm_ignores_pulses got=%b exp=1", bus.alarm);
    end
    step(0, 0, 1, 4'he);
    step(0, 0, 0, 4'he);
    total++;
    if (bus.alarm !== 1'b0 || bus.locked_out !== 1'b1 || bus.key_out !== 4'hf) begin
      bad++; $display("FAIL alarm_cleared got al=%b lk=%b key=%h exp al=0 lk=1 key=f",
                      bus.alarm, bus.locked_out, bus.key_out);
    end
    step(0, 0, 0, 4'hf);
    total++;
    if (bus.locked_out !== 1'b0) begin
      bad++; $display("FAIL alarm_rearm got lk=%b exp=0", bus.locked_out);
    end
    repeat (3) step(1, 0, 0, 4'hf);
    total++;
    if (bus.remaining_s !== 8'd2) begin
      bad++; $display("FAIL alarm_penalty_reset got=%0d exp=2", bus.remaining_s);
    end
    run_out_penalty("alarm");
  endtask

  task automatic test_same_cycle();
    repeat (2) step(1, 0, 0, 4'hf);
    step(1, 1, 0, 4'hf);
    total++;
    if (bus.fail_count !== 4'd0 || bus.locked_out !== 1'b0) begin
      bad++; $display("FAIL same_cycle_armed got cnt=%0d lk=%b exp cnt=0 lk=0", bus.fail_count, bus.locked_out);
    end
    repeat (3) step(1, 0, 0, 4'hf);
    for (int i = 1; i <= 10; i++) begin
      step(i == 5, i == 5, 0, 4'hf);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL same_cycle_pen%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (bus.remaining_s !== 8'd1 || bus.locked_out !== 1'b1) begin
      bad++; $display("FAIL same_cycle_countdown got rem=%0d lk=%b exp rem=1 lk=1", bus.remaining_s, bus.locked_out);
    end
    run_out_penalty("same_cycle");
  endtask

  task automatic test_reset_mid();
    int budget = 60;
    repeat (3) step(1, 0, 0, 4'hf);
    while (exp_rem() != 1 && budget > 0) begin
      step(0, 0, 0, 4'hf);
      budget--;
    end
    total++;
    if (budget == 0 || bus.remaining_s !== 8'd1) begin
      bad++; $display("FAIL reset_mid_reach got rem=%0d exp=1", bus.remaining_s);
    end
    #2;
    bus.key_in = 4'h9; cur_key = 4'h9;
    rst = 1'b1;
    #1;
    total++;
    if (obs_vec() !== {4'h9, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      bad++; $display("FAIL reset_mid_async got=%h exp=%h", obs_vec(), {4'h9, 1'b0, 1'b0, 8'd0, 4'd0});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1, 0, 0, 4'hf);
    total++;
    if (bus.remaining_s !== 8'd2) begin
      bad++; $display("FAIL reset_mid_history got=%0d exp=2", bus.remaining_s);
    end
    run_out_penalty("reset_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit f, p, c;
      logic [3:0] k;
      f = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 31) == 0);
      k = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom_range(0, 15));
      step(f, p, c, k);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    cur_key = 4'ha;
    test_reset();
    test_fail_pass();
    test_lockout();
    test_hold_key();
    test_alarm();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
